// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and the data stage.
// Optional performance counters are built only when SRAM_ARB_PERF_EN is defined.
module sram_port_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ok,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ok,
   output logic        mem_en,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stallreq_inst,
   output logic        stallreq_data,
   output logic [31:0] perf_inst_grants,
   output logic [31:0] perf_data_grants,
   output logic [31:0] perf_conflicts
);

   localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
   localparam logic [2:0] MEM_LAT_C    = 3'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [2:0]  lat_q, lat_d;
   logic        grant_inst_q, grant_inst_d;
   logic        mem_en_q, mem_en_d;
   logic [3:0]  mem_wen_q, mem_wen_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        inst_ok_q, inst_ok_d;
   logic        data_ok_q, data_ok_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;

   logic        idle_s;
   logic        conflict_s;
   logic        pick_inst_s;
   logic        pick_data_s;

   assign idle_s      = (state_q == IDLE);
   assign conflict_s  = idle_s & inst_req & data_req;
   // Data wins a contest unless the fetch side has been passed over STARVE_MAX times.
   assign pick_inst_s = idle_s & inst_req & (~data_req | (starve_q == STARVE_MAX_C));
   assign pick_data_s = idle_s & data_req & ~pick_inst_s;

   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      lat_d        = lat_q;
      grant_inst_d = grant_inst_q;
      mem_en_d     = 1'b0;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      inst_ok_d    = 1'b0;
      data_ok_d    = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_inst_s) begin
               grant_inst_d = 1'b1;
               mem_en_d     = 1'b1;
               mem_wen_d    = 4'b0000;
               mem_addr_d   = inst_addr;
               mem_wdata_d  = 32'h0000_0000;
               starve_d     = 4'd0;
               state_d      = ISSUE;
            end else if (pick_data_s) begin
               grant_inst_d = 1'b0;
               mem_en_d     = 1'b1;
               mem_wen_d    = data_wen;
               mem_addr_d   = data_addr;
               mem_wdata_d  = data_wdata;
               if (inst_req && (starve_q < STARVE_MAX_C)) begin
                  starve_d = starve_q + 4'd1;
               end else begin
                  starve_d = starve_q;
               end
               state_d      = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            lat_d   = MEM_LAT_C;
            state_d = WAIT;
         end
         WAIT: begin
            // lat_q reaches 1 in the cycle mem_rdata is valid.
            if (lat_q == 3'd1) begin
               lat_d   = 3'd0;
               state_d = RESP;
               if (grant_inst_q) begin
                  inst_ok_d    = 1'b1;
                  inst_rdata_d = mem_rdata;
               end else begin
                  data_ok_d = 1'b1;
                  if (mem_wen_q == 4'b0000) begin
                     data_rdata_d = mem_rdata;
                  end else begin
                     data_rdata_d = data_rdata_q;
                  end
               end
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state and registered memory / response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_q     <= 4'd0;
         lat_q        <= 3'd0;
         grant_inst_q <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_wen_q    <= 4'b0000;
         mem_addr_q   <= 32'h0000_0000;
         mem_wdata_q  <= 32'h0000_0000;
         inst_ok_q    <= 1'b0;
         data_ok_q    <= 1'b0;
         inst_rdata_q <= 32'h0000_0000;
         data_rdata_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         lat_q        <= lat_d;
         grant_inst_q <= grant_inst_d;
         mem_en_q     <= mem_en_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_ok_q    <= inst_ok_d;
         data_ok_q    <= data_ok_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign mem_en        = mem_en_q;
   assign mem_wen       = mem_wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign inst_ok       = inst_ok_q;
   assign data_ok       = data_ok_q;
   assign inst_rdata    = inst_rdata_q;
   assign data_rdata    = data_rdata_q;
   assign stallreq_inst = inst_req & ~inst_ok_q;
   assign stallreq_data = data_req & ~data_ok_q;

`ifdef SRAM_ARB_PERF_EN
   logic [31:0] perf_inst_q, perf_inst_d;
   logic [31:0] perf_data_q, perf_data_d;
   logic [31:0] perf_conf_q, perf_conf_d;

   always_comb begin
      perf_inst_d = perf_inst_q;
      perf_data_d = perf_data_q;
      perf_conf_d = perf_conf_q;
      if (pick_inst_s) begin
         perf_inst_d = perf_inst_q + 32'd1;
      end else begin
         perf_inst_d = perf_inst_q;
      end
      if (pick_data_s) begin
         perf_data_d = perf_data_q + 32'd1;
      end else begin
         perf_data_d = perf_data_q;
      end
      if (conflict_s) begin
         perf_conf_d = perf_conf_q + 32'd1;
      end else begin
         perf_conf_d = perf_conf_q;
      end
   end

   // Free-running grant and contention counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_inst_q <= 32'h0000_0000;
         perf_data_q <= 32'h0000_0000;
         perf_conf_q <= 32'h0000_0000;
      end else begin
         perf_inst_q <= perf_inst_d;
         perf_data_q <= perf_data_d;
         perf_conf_q <= perf_conf_d;
      end
   end

   assign perf_inst_grants = perf_inst_q;
   assign perf_data_grants = perf_data_q;
   assign perf_conflicts   = perf_conf_q;
`else
   logic unused_perf_s;
   assign unused_perf_s    = conflict_s;
   assign perf_inst_grants = 32'h0000_0000;
   assign perf_data_grants = 32'h0000_0000;
   assign perf_conflicts   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT/STARVE_MAX = 1/4, 1/2, 3/4) share stimulus.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] inst_rdata_s [3];
   logic        inst_ok_s    [3];
   logic [31:0] data_rdata_s [3];
   logic        data_ok_s    [3];
   logic        mem_en_s     [3];
   logic [3:0]  mem_wen_s    [3];
   logic [31:0] mem_addr_s   [3];
   logic [31:0] mem_wdata_s  [3];
   logic        stall_i_s    [3];
   logic        stall_d_s    [3];
   logic [31:0] perf_i_s     [3];
   logic [31:0] perf_d_s     [3];
   logic [31:0] perf_c_s     [3];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sram_port_arbiter #(
         .MEM_LAT    ((g == 2) ? 3 : 1),
         .STARVE_MAX ((g == 1) ? 2 : 4)
      ) u_dut (
         .clk              (clk),
         .rst              (rst),
         .inst_req         (inst_req),
         .inst_addr        (inst_addr),
         .inst_rdata       (inst_rdata_s[g]),
         .inst_ok          (inst_ok_s[g]),
         .data_req         (data_req),
         .data_wen         (data_wen),
         .data_addr        (data_addr),
         .data_wdata       (data_wdata),
         .data_rdata       (data_rdata_s[g]),
         .data_ok          (data_ok_s[g]),
         .mem_en           (mem_en_s[g]),
         .mem_wen          (mem_wen_s[g]),
         .mem_addr         (mem_addr_s[g]),
         .mem_wdata        (mem_wdata_s[g]),
         .mem_rdata        (mem_rdata),
         .stallreq_inst    (stall_i_s[g]),
         .stallreq_data    (stall_d_s[g]),
         .perf_inst_grants (perf_i_s[g]),
         .perf_data_grants (perf_d_s[g]),
         .perf_conflicts   (perf_c_s[g])
      );
   end

   task automatic do_reset();
      inst_req   = 1'b0;
      data_req   = 1'b0;
      data_wen   = 4'b0000;
      inst_addr  = 32'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      mem_rdata  = 32'h0;
      rst        = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ok(input int idx, output bit was_inst, output bit found);
      found    = 1'b0;
      was_inst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (inst_ok_s[idx] || data_ok_s[idx]) begin
            found    = 1'b1;
            was_inst = inst_ok_s[idx];
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if ({mem_en_s[0], mem_wen_s[0], inst_ok_s[0], data_ok_s[0]} !== 7'b0) $display("FAIL reset_ctrl got %b want 0", {mem_en_s[0], mem_wen_s[0], inst_ok_s[0], data_ok_s[0]}); else passes++;
      checks++; if ({mem_addr_s[0], mem_wdata_s[0], inst_rdata_s[0], data_rdata_s[0]} !== 128'h0) $display("FAIL reset_data got %h want 0", {mem_addr_s[0], mem_wdata_s[0], inst_rdata_s[0], data_rdata_s[0]}); else passes++;
   endtask

   task automatic test_inst_fetch();
      do_reset();
      mem_rdata = 32'h3C1D0001;
      inst_addr = 32'hBFC00000;
      inst_req  = 1'b1;
      #1;
      checks++; if (stall_i_s[0] !== 1'b1) $display("FAIL fetch_stall_t got %b want 1", stall_i_s[0]); else passes++;
      @(negedge clk);
      checks++; if (mem_en_s[0] !== 1'b1 || mem_addr_s[0] !== 32'hBFC00000 || mem_wen_s[0] !== 4'b0) $display("FAIL fetch_issue got en=%b addr=%h wen=%b want 1 bfc00000 0", mem_en_s[0], mem_addr_s[0], mem_wen_s[0]); else passes++;
      @(negedge clk);
      checks++; if (mem_en_s[0] !== 1'b0 || inst_ok_s[0] !== 1'b0 || stall_i_s[0] !== 1'b1) $display("FAIL fetch_wait got en=%b ok=%b stall=%b want 0 0 1", mem_en_s[0], inst_ok_s[0], stall_i_s[0]); else passes++;
      @(negedge clk);
      checks++; if (inst_ok_s[0] !== 1'b1 || inst_rdata_s[0] !== 32'h3C1D0001 || stall_i_s[0] !== 1'b0) $display("FAIL fetch_ok got ok=%b rdata=%h stall=%b want 1 3c1d0001 0", inst_ok_s[0], inst_rdata_s[0], stall_i_s[0]); else passes++;
      inst_req = 1'b0;
      @(negedge clk);
      checks++; if (inst_ok_s[0] !== 1'b0 || inst_rdata_s[0] !== 32'h3C1D0001) $display("FAIL fetch_hold got ok=%b rdata=%h want 0 3c1d0001", inst_ok_s[0], inst_rdata_s[0]); else passes++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      mem_rdata  = 32'h12345678;
      inst_addr  = 32'hBFC00004;
      data_addr  = 32'h80000010;
      data_wdata = 32'hDEADBEEF;
      data_wen   = 4'b1111;
      inst_req   = 1'b1;
      data_req   = 1'b1;
      @(negedge clk);
      checks++; if (mem_en_s[0] !== 1'b1 || mem_wen_s[0] !== 4'b1111 || mem_addr_s[0] !== 32'h80000010 || mem_wdata_s[0] !== 32'hDEADBEEF) $display("FAIL b2b_store_issue got en=%b wen=%b addr=%h wd=%h want 1 1111 80000010 deadbeef", mem_en_s[0], mem_wen_s[0], mem_addr_s[0], mem_wdata_s[0]); else passes++;
      @(negedge clk);
      @(negedge clk);
      checks++; if (data_ok_s[0] !== 1'b1 || inst_ok_s[0] !== 1'b0 || data_rdata_s[0] !== 32'h0) $display("FAIL b2b_store_ok got dok=%b iok=%b drd=%h want 1 0 0", data_ok_s[0], inst_ok_s[0], data_rdata_s[0]); else passes++;
      data_req = 1'b0;
      data_wen = 4'b0000;
      @(negedge clk);
      checks++; if (mem_en_s[0] !== 1'b0) $display("FAIL b2b_idle_gap got en=%b want 0", mem_en_s[0]); else passes++;
      @(negedge clk);
      checks++; if (mem_en_s[0] !== 1'b1 || mem_addr_s[0] !== 32'hBFC00004 || mem_wen_s[0] !== 4'b0 || mem_wdata_s[0] !== 32'h0) $display("FAIL b2b_inst_issue got en=%b addr=%h wen=%b wd=%h want 1 bfc00004 0 0", mem_en_s[0], mem_addr_s[0], mem_wen_s[0], mem_wdata_s[0]); else passes++;
      @(negedge clk);
      @(negedge clk);
      checks++; if (inst_ok_s[0] !== 1'b1 || data_ok_s[0] !== 1'b0 || inst_rdata_s[0] !== 32'h12345678 || data_rdata_s[0] !== 32'h0) $display("FAIL b2b_inst_ok got iok=%b dok=%b ird=%h drd=%h want 1 0 12345678 0", inst_ok_s[0], data_ok_s[0], inst_rdata_s[0], data_rdata_s[0]); else passes++;
      inst_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      bit was_inst;
      bit found;
      do_reset();
      inst_addr = 32'hBFC00100;
      data_addr = 32'h80000100;
      inst_req  = 1'b1;
      data_req  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_ok(1, was_inst, found);
         checks++; if (!found || was_inst !== (k % 3 == 2)) $display("FAIL starve_order_%0d got found=%b inst=%b want 1 %b", k, found, was_inst, (k % 3 == 2)); else passes++;
         if (k == 5) begin
            inst_req = 1'b0;
            data_req = 1'b0;
         end else begin
            inst_req = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_long_latency();
      do_reset();
      mem_rdata = 32'hBADBAD00;
      data_addr = 32'h80000020;
      data_wen  = 4'b0000;
      data_req  = 1'b1;
      @(negedge clk);
      checks++; if (mem_en_s[2] !== 1'b1 || mem_addr_s[2] !== 32'h80000020) $display("FAIL lat3_issue got en=%b addr=%h want 1 80000020", mem_en_s[2], mem_addr_s[2]); else passes++;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_en_s[2] !== 1'b0 || data_ok_s[2] !== 1'b0) $display("FAIL lat3_wait got en=%b ok=%b want 0 0", mem_en_s[2], data_ok_s[2]); else passes++;
      @(negedge clk);
      mem_rdata = 32'hCAFEF00D;
      checks++; if (data_ok_s[2] !== 1'b0 || mem_en_s[2] !== 1'b0) $display("FAIL lat3_early got ok=%b en=%b want 0 0", data_ok_s[2], mem_en_s[2]); else passes++;
      @(negedge clk);
      mem_rdata = 32'hBADBAD00;
      checks++; if (data_ok_s[2] !== 1'b1 || data_rdata_s[2] !== 32'hCAFEF00D || mem_en_s[2] !== 1'b0) $display("FAIL lat3_ok got ok=%b rdata=%h en=%b want 1 cafef00d 0", data_ok_s[2], data_rdata_s[2], mem_en_s[2]); else passes++;
      data_req = 1'b0;
      @(negedge clk);
      checks++; if (data_ok_s[2] !== 1'b0 || data_rdata_s[2] !== 32'hCAFEF00D) $display("FAIL lat3_hold got ok=%b rdata=%h want 0 cafef00d", data_ok_s[2], data_rdata_s[2]); else passes++;
   endtask

   task automatic test_reset_midflight();
      bit seen_ok;
      mem_rdata = 32'h11112222;
      data_addr = 32'h80000030;
      data_req  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b1;
      data_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({mem_en_s[2], mem_wen_s[2], data_ok_s[2], inst_ok_s[2]} !== 7'b0 || {mem_addr_s[2], data_rdata_s[2], inst_rdata_s[2]} !== 96'h0) $display("FAIL midrst_clear got en=%b addr=%h drd=%h dok=%b want 0 0 0 0", mem_en_s[2], mem_addr_s[2], data_rdata_s[2], data_ok_s[2]); else passes++;
      seen_ok = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (data_ok_s[2] || mem_en_s[2]) seen_ok = 1'b1;
      end
      checks++; if (seen_ok !== 1'b0) $display("FAIL midrst_dropped got activity=%b want 0", seen_ok); else passes++;
      data_addr = 32'h80000040;
      data_req  = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (data_ok_s[2]) seen_ok = 1'b1;
      end
      checks++; if (seen_ok !== 1'b0) $display("FAIL midrst_early_ok got %b want 0", seen_ok); else passes++;
      @(negedge clk);
      checks++; if (data_ok_s[2] !== 1'b1 || data_rdata_s[2] !== 32'h11112222) $display("FAIL midrst_fresh got ok=%b rdata=%h want 1 11112222", data_ok_s[2], data_rdata_s[2]); else passes++;
      data_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_perf();
      bit was_inst;
      bit found;
      logic [31:0] exp_i, exp_d, exp_c;
`ifdef SRAM_ARB_PERF_EN
      exp_i = 32'd5; exp_d = 32'd2; exp_c = 32'd3;
`else
      exp_i = 32'd0; exp_d = 32'd0; exp_c = 32'd0;
`endif
      do_reset();
      inst_addr = 32'hBFC00200;
      data_addr = 32'h80000200;
      inst_req  = 1'b1;
      data_req  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ok(1, was_inst, found);
         checks++; if (!found) $display("FAIL perf_contest_%0d got timeout want ok", k); else passes++;
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         inst_req = 1'b1;
         wait_ok(1, was_inst, found);
         checks++; if (!found || !was_inst) $display("FAIL perf_inst_%0d got found=%b inst=%b want 1 1", k, found, was_inst); else passes++;
         inst_req = 1'b0;
      end
      @(negedge clk);
      checks++; if (perf_i_s[1] !== exp_i || perf_d_s[1] !== exp_d || perf_c_s[1] !== exp_c) $display("FAIL perf_counts got i=%0d d=%0d c=%0d want %0d %0d %0d", perf_i_s[1], perf_d_s[1], perf_c_s[1], exp_i, exp_d, exp_c); else passes++;
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_inst_fetch();
      test_back_to_back();
      test_starvation();
      test_long_latency();
      test_reset_midflight();
      test_perf();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM-like memory between the instruction-fetch requester (IF) and the data requester (MEM stage, lw/sw).
- Serialises accesses with a small FSM and returns read data with one-cycle ok pulses.
- Raises per-requester stall requests that the pipeline control unit folds into the stall bus.
- Data side has priority. A starvation counter guarantees instruction-fetch progress.

Parameters:
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4, consecutive contested data grants after which the next contested grant goes to the instruction side; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- inst_req  in  1  fetch request; held high until inst_ok
- inst_addr  in  32  fetch address; stable while inst_req is high
- inst_rdata  out  32  fetched word; valid in the inst_ok cycle, held until the next inst_ok
- inst_ok  out  1  one-cycle completion pulse
- data_req  in  1  data request; held high until data_ok
- data_wen  in  4  byte write enables; 0 = load
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_rdata  out  32  load result; valid in the data_ok cycle, held otherwise
- data_ok  out  1  one-cycle completion pulse (loads and stores)
- mem_en  out  1  memory access strobe, one cycle per access
- mem_wen  out  4  memory byte write enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- stallreq_inst  out  1  inst_req & ~inst_ok (combinational)
- stallreq_data  out  1  data_req & ~data_ok (combinational)
- perf_inst_grants  out  32  see Optional Feature
- perf_data_grants  out  32  see Optional Feature
- perf_conflicts  out  32  see Optional Feature

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- On reset:
  - state = IDLE; starve_cnt = 0; lat_cnt = 0.
  - mem_en = 0; mem_wen = 0; mem_addr = 0; mem_wdata = 0.
  - inst_ok = 0; data_ok = 0; inst_rdata = 0; data_rdata = 0.
  - Any in-flight access is dropped; no ok is issued for it.
- All mem_* and ok/rdata outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: samples the requests.
  - Neither request: stay in IDLE.
  - Otherwise grant one requester, latch its addr/wen/wdata (inst side uses wen = 0, wdata = 0) and go to ISSUE.
- Grant rule:
  - Only one request: grant it.
  - Both requests and starve_cnt == STARVE_MAX: grant inst.
  - Both requests otherwise: grant data.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a data grant while inst_req is high.
  - Clears on any inst grant.
  - Unchanged on an uncontested data grant.
- ISSUE: mem_en = 1 for exactly this cycle, with the latched mem_wen/addr/wdata. Load lat_cnt = MEM_LAT and go to WAIT.
- WAIT: lat_cnt decrements each cycle. In the cycle where mem_rdata is valid (MEM_LAT cycles after ISSUE):
  - Capture mem_rdata into the granted side's rdata register; a store does not update data_rdata.
  - Go to RESP.
- RESP: the granted side's ok = 1 for this single cycle; requests are not sampled; next state is IDLE.
- Requesters must deassert or change their request in the cycle after ok.
- Latency: request first seen in IDLE at cycle t → mem_en at t+1 → ok at t+2+MEM_LAT. For MEM_LAT = 1, ok arrives at t+3.
- Minimum spacing between two back-to-back accesses is MEM_LAT+3 cycles.
- A request that is raised or dropped while a different access is in flight is ignored until IDLE.
- mem_wen, mem_addr and mem_wdata hold their last value when mem_en = 0.
- inst_ok and data_ok are never high in the same cycle.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- Defined:
  - perf_inst_grants and perf_data_grants are 32-bit counters, each incremented on its side's grant.
  - perf_conflicts increments on each IDLE cycle where both requests are high.
  - All three counters wrap at 2^32 and clear on reset.
- Undefined: the perf_* ports remain present, are tied to 0, and no counter flops are synthesised.

Test Plan:
- MEM_LAT=1; inst_req alone, addr 0xBFC00000, mem_rdata = 0x3C1D0001 → mem_en at t+1 with mem_addr 0xBFC00000; inst_ok at t+3; inst_rdata = 0x3C1D0001; stallreq_inst high for t..t+2.
- Both requests at t; data is a store (wen 4'b1111, addr 0x80000010, wdata 0xDEADBEEF) → data granted first with mem_wen = 1111; data_ok at t+3; inst granted at t+4; inst_ok at t+7; data_rdata unchanged.
- STARVE_MAX=2; inst_req held high, data_req re-raised every cycle after data_ok → grant order data, data, inst, data, data, inst; starve_cnt never exceeds 2.
- MEM_LAT=3; single load → mem_en at t+1; mem_rdata sampled at t+4; data_ok at t+5; no second mem_en until the next IDLE.
- rst asserted in the WAIT state of a load → next cycle all outputs are 0 and no data_ok occurs; a fresh request afterwards completes with the normal latency.
- SRAM_ARB_PERF_EN defined; 3 contested cycles plus 5 inst and 2 data grants → perf_conflicts = 3, perf_inst_grants = 5, perf_data_grants = 2. With the macro undefined → all perf_* read 0.
